// File: rtl/ai_sa_write_arbiter_pkg.sv
// Shared helpers for the slave-side write arbiter: width derivation and the
// ready level used to sink responses that carry an out-of-range master index.
package ai_sa_write_arbiter_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

  // Index width never collapses to zero, even for a single master.
  function automatic int idx_width(input int count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

  localparam logic B_SINK_READY = 1'b1;

endpackage

// File: rtl/ai_sa_write_arbiter_sync_fifo.sv
// Small synchronous FIFO with a combinational head, used to remember the
// order in which AW grants were issued so W beats follow the same order.
module ai_sync_fifo
  import ai_sa_write_arbiter_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int CNT_W = clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty    = (count_reg == '0);
  assign pop_data = mem[rd_ptr_reg];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/ai_sa_write_arbiter.sv
// Per-slave write arbiter: round-robin AW grant into a registered AW stage,
// W routing in grant order, and B routing by the master index in the ID.
module ai_sa_write_arbiter
  import ai_sa_write_arbiter_pkg::*;
#(
  parameter int MST_AMT           = 2,
  parameter int DATA_WIDTH        = 32,
  parameter int ADDR_WIDTH        = 32,
  parameter int TRANS_MST_ID_W    = 5,
  parameter int TRANS_DATA_LEN_W  = 3,
  parameter int TRANS_DATA_SIZE_W = 3,
  parameter int TRANS_WR_RESP_W   = 2,
  parameter int OUTST_DEPTH       = 4,
  localparam int MST_IDX_W        = idx_width(MST_AMT),
  localparam int TRANS_SLV_ID_W   = MST_IDX_W + TRANS_MST_ID_W
) (
  input  logic                                  ACLK_i,
  input  logic                                  ARESET_i,
  input  logic [MST_AMT*TRANS_MST_ID_W-1:0]     m_AWID_i,
  input  logic [MST_AMT*ADDR_WIDTH-1:0]         m_AWADDR_i,
  input  logic [MST_AMT*TRANS_DATA_LEN_W-1:0]   m_AWLEN_i,
  input  logic [MST_AMT*TRANS_DATA_SIZE_W-1:0]  m_AWSIZE_i,
  input  logic [MST_AMT-1:0]                    m_AWVALID_i,
  output logic [MST_AMT-1:0]                    m_AWREADY_o,
  input  logic [MST_AMT*DATA_WIDTH-1:0]         m_WDATA_i,
  input  logic [MST_AMT-1:0]                    m_WLAST_i,
  input  logic [MST_AMT-1:0]                    m_WVALID_i,
  output logic [MST_AMT-1:0]                    m_WREADY_o,
  output logic [TRANS_MST_ID_W-1:0]             m_BID_o,
  output logic [TRANS_WR_RESP_W-1:0]            m_BRESP_o,
  output logic [MST_AMT-1:0]                    m_BVALID_o,
  input  logic [MST_AMT-1:0]                    m_BREADY_i,
  output logic [TRANS_SLV_ID_W-1:0]             s_AWID_o,
  output logic [ADDR_WIDTH-1:0]                 s_AWADDR_o,
  output logic [TRANS_DATA_LEN_W-1:0]           s_AWLEN_o,
  output logic [TRANS_DATA_SIZE_W-1:0]          s_AWSIZE_o,
  output logic                                  s_AWVALID_o,
  input  logic                                  s_AWREADY_i,
  output logic [DATA_WIDTH-1:0]                 s_WDATA_o,
  output logic                                  s_WLAST_o,
  output logic                                  s_WVALID_o,
  input  logic                                  s_WREADY_i,
  input  logic [TRANS_SLV_ID_W-1:0]             s_BID_i,
  input  logic [TRANS_WR_RESP_W-1:0]            s_BRESP_i,
  input  logic                                  s_BVALID_i,
  output logic                                  s_BREADY_o
);

  // Per-master views indexed by master number (master 0 sits in the MSBs).
  logic                         aw_valid [MST_AMT];
  logic [TRANS_MST_ID_W-1:0]    aw_id    [MST_AMT];
  logic [ADDR_WIDTH-1:0]        aw_addr  [MST_AMT];
  logic [TRANS_DATA_LEN_W-1:0]  aw_len   [MST_AMT];
  logic [TRANS_DATA_SIZE_W-1:0] aw_size  [MST_AMT];
  logic [DATA_WIDTH-1:0]        w_data   [MST_AMT];
  logic                         w_last   [MST_AMT];
  logic                         w_valid  [MST_AMT];
  logic                         b_ready  [MST_AMT];
  logic                         aw_ready [MST_AMT];
  logic                         w_ready  [MST_AMT];
  logic                         b_valid  [MST_AMT];

  for (genvar gi = 0; gi < MST_AMT; gi++) begin : g_mst
    localparam int BIT = MST_AMT - 1 - gi;
    assign aw_valid[gi]     = m_AWVALID_i[BIT];
    assign aw_id[gi]        = m_AWID_i[BIT*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    assign aw_addr[gi]      = m_AWADDR_i[BIT*ADDR_WIDTH +: ADDR_WIDTH];
    assign aw_len[gi]       = m_AWLEN_i[BIT*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
    assign aw_size[gi]      = m_AWSIZE_i[BIT*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
    assign w_data[gi]       = m_WDATA_i[BIT*DATA_WIDTH +: DATA_WIDTH];
    assign w_last[gi]       = m_WLAST_i[BIT];
    assign w_valid[gi]      = m_WVALID_i[BIT];
    assign b_ready[gi]      = m_BREADY_i[BIT];
    assign m_AWREADY_o[BIT] = aw_ready[gi];
    assign m_WREADY_o[BIT]  = w_ready[gi];
    assign m_BVALID_o[BIT]  = b_valid[gi];
  end

  logic                         out_valid_reg;
  logic [TRANS_SLV_ID_W-1:0]    out_id_reg;
  logic [ADDR_WIDTH-1:0]        out_addr_reg;
  logic [TRANS_DATA_LEN_W-1:0]  out_len_reg;
  logic [TRANS_DATA_SIZE_W-1:0] out_size_reg;
  logic [MST_IDX_W-1:0]         rr_ptr_reg;

  logic                 any_req;
  logic [MST_IDX_W-1:0] winner;
  logic                 grant;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [MST_IDX_W-1:0] fifo_head;
  logic [MST_IDX_W-1:0] head;
  logic                 w_pop;
  logic [MST_IDX_W-1:0] b_idx;

  // Two passes give the upward search with wrap starting just past rr_ptr_reg.
  always_comb begin
    any_req = 1'b0;
    winner  = '0;
    for (int i = 0; i < MST_AMT; i++) begin
      if (!any_req && aw_valid[i] && (i > int'(rr_ptr_reg))) begin
        any_req = 1'b1;
        winner  = MST_IDX_W'(i);
      end
    end
    for (int i = 0; i < MST_AMT; i++) begin
      if (!any_req && aw_valid[i] && (i <= int'(rr_ptr_reg))) begin
        any_req = 1'b1;
        winner  = MST_IDX_W'(i);
      end
    end
  end

  assign grant = (~out_valid_reg | s_AWREADY_i) & ~fifo_full & any_req;

  always_comb begin
    for (int i = 0; i < MST_AMT; i++) begin
      aw_ready[i] = grant && (int'(winner) == i);
    end
  end

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      out_valid_reg <= 1'b0;
      out_id_reg    <= '0;
      out_addr_reg  <= '0;
      out_len_reg   <= '0;
      out_size_reg  <= '0;
      rr_ptr_reg    <= MST_IDX_W'(MST_AMT - 1);
    end else if (grant) begin
      out_valid_reg <= 1'b1;
      out_id_reg    <= {winner, aw_id[winner]};
      out_addr_reg  <= aw_addr[winner];
      out_len_reg   <= aw_len[winner];
      out_size_reg  <= aw_size[winner];
      rr_ptr_reg    <= winner;
    end else if (s_AWREADY_i) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign s_AWVALID_o = out_valid_reg;
  assign s_AWID_o    = out_id_reg;
  assign s_AWADDR_o  = out_addr_reg;
  assign s_AWLEN_o   = out_len_reg;
  assign s_AWSIZE_o  = out_size_reg;

  ai_sync_fifo #(
    .WIDTH (MST_IDX_W),
    .DEPTH (OUTST_DEPTH)
  ) u_order_fifo (
    .clk       (ACLK_i),
    .srst      (ARESET_i),
    .push      (grant),
    .push_data (winner),
    .pop       (w_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Head is forced to a legal index while empty so the W mux never sees junk.
  assign head        = fifo_empty ? '0 : fifo_head;
  assign s_WDATA_o   = w_data[head];
  assign s_WLAST_o   = w_last[head];
  assign s_WVALID_o  = ~fifo_empty & w_valid[head];
  assign w_pop       = s_WVALID_o & s_WREADY_i & s_WLAST_o;

  always_comb begin
    for (int i = 0; i < MST_AMT; i++) begin
      w_ready[i] = ~fifo_empty && s_WREADY_i && (int'(head) == i);
    end
  end

  assign b_idx     = s_BID_i[TRANS_SLV_ID_W-1 -: MST_IDX_W];
  assign m_BID_o   = s_BID_i[TRANS_MST_ID_W-1:0];
  assign m_BRESP_o = s_BRESP_i;

  // An index with no matching master leaves the sink ready level in place.
  always_comb begin
    s_BREADY_o = B_SINK_READY;
    for (int i = 0; i < MST_AMT; i++) begin
      b_valid[i] = s_BVALID_i && (int'(b_idx) == i);
      if (int'(b_idx) == i) s_BREADY_o = b_ready[i];
    end
  end

endmodule

// File: tb/tb_ai_sa_write_arbiter.sv
// Bench for ai_sa_write_arbiter: B routing table, directed multi-cycle
// sequences, then randomized traffic against a queue-based reference model.
module tb_ai_sa_write_arbiter;

  localparam int MST   = 2;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int IDW   = 5;
  localparam int LW    = 3;
  localparam int SW    = 3;
  localparam int RW    = 2;
  localparam int DEPTH = 4;
  localparam int SIDW  = IDW + 1;
  localparam int N     = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic srst;

  logic [MST*IDW-1:0] m_awid;
  logic [MST*AW-1:0]  m_awaddr;
  logic [MST*LW-1:0]  m_awlen;
  logic [MST*SW-1:0]  m_awsize;
  logic [MST-1:0]     m_awvalid, m_awready;
  logic [MST*DW-1:0]  m_wdata;
  logic [MST-1:0]     m_wlast, m_wvalid, m_wready;
  logic [IDW-1:0]     m_bid;
  logic [RW-1:0]      m_bresp;
  logic [MST-1:0]     m_bvalid, m_bready;
  logic [SIDW-1:0]    s_awid;
  logic [AW-1:0]      s_awaddr;
  logic [LW-1:0]      s_awlen;
  logic [SW-1:0]      s_awsize;
  logic               s_awvalid, s_awready;
  logic [DW-1:0]      s_wdata;
  logic               s_wlast, s_wvalid, s_wready;
  logic [SIDW-1:0]    s_bid;
  logic [RW-1:0]      s_bresp;
  logic               s_bvalid, s_bready;

  ai_sa_write_arbiter #(
    .MST_AMT(MST), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TRANS_MST_ID_W(IDW),
    .TRANS_DATA_LEN_W(LW), .TRANS_DATA_SIZE_W(SW), .TRANS_WR_RESP_W(RW),
    .OUTST_DEPTH(DEPTH)
  ) dut (
    .ACLK_i(clk), .ARESET_i(srst),
    .m_AWID_i(m_awid), .m_AWADDR_i(m_awaddr), .m_AWLEN_i(m_awlen),
    .m_AWSIZE_i(m_awsize), .m_AWVALID_i(m_awvalid), .m_AWREADY_o(m_awready),
    .m_WDATA_i(m_wdata), .m_WLAST_i(m_wlast), .m_WVALID_i(m_wvalid),
    .m_WREADY_o(m_wready), .m_BID_o(m_bid), .m_BRESP_o(m_bresp),
    .m_BVALID_o(m_bvalid), .m_BREADY_i(m_bready),
    .s_AWID_o(s_awid), .s_AWADDR_o(s_awaddr), .s_AWLEN_o(s_awlen),
    .s_AWSIZE_o(s_awsize), .s_AWVALID_o(s_awvalid), .s_AWREADY_i(s_awready),
    .s_WDATA_o(s_wdata), .s_WLAST_o(s_wlast), .s_WVALID_o(s_wvalid),
    .s_WREADY_i(s_wready), .s_BID_i(s_bid), .s_BRESP_i(s_bresp),
    .s_BVALID_i(s_bvalid), .s_BREADY_o(s_bready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Master m occupies bit MST-1-m of every per-master vector.
  function automatic int mb(input int m);
    return MST - 1 - m;
  endfunction

  task automatic set_aw(input int m, input logic v, input logic [IDW-1:0] id,
                        input logic [AW-1:0] addr, input logic [LW-1:0] len);
    m_awvalid[mb(m)]          = v;
    m_awid[mb(m)*IDW +: IDW]  = id;
    m_awaddr[mb(m)*AW +: AW]  = addr;
    m_awlen[mb(m)*LW +: LW]   = len;
    m_awsize[mb(m)*SW +: SW]  = 3'd2;
  endtask

  task automatic set_w(input int m, input logic v, input logic [DW-1:0] data, input logic last);
    m_wvalid[mb(m)]         = v;
    m_wdata[mb(m)*DW +: DW] = data;
    m_wlast[mb(m)]          = last;
  endtask

  task automatic idle();
    m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awvalid = '0;
    m_wdata = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
    s_awready = 1'b1; s_wready = 1'b1; s_bid = '0; s_bresp = '0; s_bvalid = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    srst = 1'b1;
    step();
    step();
    srst = 1'b0;
  endtask

  function automatic logic [DW-1:0] beat_data(input int m, input int t, input int b);
    return {8'(m), 8'(t), 8'(b), 8'hA5};
  endfunction

  typedef struct {
    logic [SIDW-1:0] bid;
    logic [RW-1:0]   bresp;
    logic            bvalid;
    logic [MST-1:0]  bready;
    logic [MST-1:0]  exp_bvalid;
    logic [IDW-1:0]  exp_bid;
    logic            exp_sready;
  } bvec_t;

  typedef struct { int m; int t; } gnt_t;

  bvec_t tbl[6];
  gnt_t  grant_q[$];
  int    order_q[$];
  int    aw_sent[MST], w_txn[MST], w_beat[MST];
  bit    aw_hold[MST], w_hold[MST];
  logic [AW-1:0] t_addr[MST][N];
  int    t_len[MST][N];
  int    last_winner;

  initial begin
    srst = 1'b1;
    idle();
    tbl[0] = '{6'h03, 2'd0, 1'b1, 2'b10, 2'b10, 5'h03, 1'b1};
    tbl[1] = '{6'h03, 2'd0, 1'b1, 2'b01, 2'b10, 5'h03, 1'b0};
    tbl[2] = '{6'h3F, 2'd1, 1'b1, 2'b01, 2'b01, 5'h1F, 1'b1};
    tbl[3] = '{6'h3F, 2'd1, 1'b0, 2'b00, 2'b00, 5'h1F, 1'b0};
    tbl[4] = '{6'h27, 2'd2, 1'b1, 2'b10, 2'b01, 5'h07, 1'b0};
    tbl[5] = '{6'h10, 2'd3, 1'b0, 2'b11, 2'b00, 5'h10, 1'b1};

    do_reset();
    check("rst_awvalid", s_awvalid, 1'b0);
    check("rst_awid", s_awid, '0);
    check("rst_wvalid", s_wvalid, 1'b0);
    check("rst_wready", m_wready, '0);
    check("rst_awready", m_awready, '0);
    $display("reset: awvalid=%0b wvalid=%0b wready=%b", s_awvalid, s_wvalid, m_wready);

    // B routing vectors.
    for (int i = 0; i < 6; i++) begin
      s_bid = tbl[i].bid; s_bresp = tbl[i].bresp; s_bvalid = tbl[i].bvalid; m_bready = tbl[i].bready;
      #1;
      check("b_tbl_bvalid", m_bvalid, tbl[i].exp_bvalid);
      check("b_tbl_bid", m_bid, tbl[i].exp_bid);
      check("b_tbl_bresp", m_bresp, tbl[i].bresp);
      check("b_tbl_sready", s_bready, tbl[i].exp_sready);
      $display("b vec %0d: bid=%h bvalid=%b sready=%b", i, s_bid, m_bvalid, s_bready);
    end
    idle();

    // Simultaneous requests: master 0 first, then master 1; W in grant order.
    set_aw(0, 1'b1, 5'd3, 32'h1000, 3'd0);
    set_aw(1, 1'b1, 5'd9, 32'h2000, 3'd0);
    #1; check("s1_grant_m0", m_awready, 2'b10);
    step(); set_aw(0, 1'b0, 5'd0, 32'h0, 3'd0); #1;
    check("s1_awvalid", s_awvalid, 1'b1);
    check("s1_awid_m0", s_awid, 6'h03);
    check("s1_awaddr_m0", s_awaddr, 32'h1000);
    check("s1_grant_m1", m_awready, 2'b01);
    step(); set_aw(1, 1'b0, 5'd0, 32'h0, 3'd0); #1;
    check("s1_awid_m1", s_awid, 6'h29);
    check("s1_awaddr_m1", s_awaddr, 32'h2000);
    step();
    check("s1_awvalid_clr", s_awvalid, 1'b0);
    set_w(1, 1'b1, 32'hBBBB0001, 1'b1); #1;
    check("s1_w_stall", s_wvalid, 1'b0);
    check("s1_wready_head0", m_wready, 2'b10);
    set_w(0, 1'b1, 32'hAAAA0001, 1'b1); #1;
    check("s1_wvalid_m0", s_wvalid, 1'b1);
    check("s1_wdata_m0", s_wdata, 32'hAAAA0001);
    step(); set_w(0, 1'b0, 32'h0, 1'b0); #1;
    check("s1_wvalid_m1", s_wvalid, 1'b1);
    check("s1_wdata_m1", s_wdata, 32'hBBBB0001);
    check("s1_wready_head1", m_wready, 2'b01);
    step(); set_w(1, 1'b0, 32'h0, 1'b0); #1;
    check("s1_w_empty_valid", s_wvalid, 1'b0);
    check("s1_w_empty_ready", m_wready, 2'b00);
    $display("seq grant order: done");

    // Slave back-pressure on AW for 5 cycles.
    do_reset();
    s_awready = 1'b0;
    set_aw(0, 1'b1, 5'd5, 32'h3000, 3'd0); #1;
    check("s2_grant", m_awready, 2'b10);
    step();
    set_aw(0, 1'b0, 5'd0, 32'h0, 3'd0);
    set_aw(1, 1'b1, 5'd7, 32'h4000, 3'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("s2_hold_valid", s_awvalid, 1'b1);
      check("s2_hold_id", s_awid, 6'h05);
      check("s2_hold_addr", s_awaddr, 32'h3000);
      check("s2_no_grant", m_awready, 2'b00);
      step();
    end
    s_awready = 1'b1; #1;
    check("s2_grant_after_accept", m_awready, 2'b01);
    step(); set_aw(1, 1'b0, 5'd0, 32'h0, 3'd0); #1;
    check("s2_next_id", s_awid, 6'h27);
    check("s2_next_addr", s_awaddr, 32'h4000);
    $display("seq aw backpressure: done");

    // Order FIFO full blocks the fifth grant until a WLAST pops.
    do_reset();
    set_aw(0, 1'b1, 5'd0, 32'h5000, 3'd0);
    for (int i = 0; i < DEPTH; i++) begin
      #1; check("s3_fill_grant", m_awready, 2'b10);
      step(); set_aw(0, 1'b1, 5'(i + 1), 32'h5000, 3'd0);
    end
    for (int i = 0; i < 3; i++) begin
      #1; check("s3_full_stall", m_awready, 2'b00);
      step();
    end
    set_w(0, 1'b1, 32'hCAFE0000, 1'b1); #1;
    check("s3_w_pass", s_wvalid, 1'b1);
    step(); set_w(0, 1'b0, 32'h0, 1'b0); #1;
    check("s3_regrant", m_awready, 2'b10);
    $display("seq fifo full: done");

    // B held while master 1 is not ready.
    do_reset();
    s_bid = 6'h27; s_bresp = 2'b10; s_bvalid = 1'b1; m_bready = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s4_bvalid", m_bvalid, 2'b01);
      check("s4_bid", m_bid, 5'h07);
      check("s4_bresp", m_bresp, 2'b10);
      check("s4_sready", s_bready, 1'b0);
      step();
    end
    m_bready = 2'b11; #1;
    check("s4_sready_go", s_bready, 1'b1);
    s_bvalid = 1'b0;
    $display("seq b hold: done");

    // Reset in the middle of a 4-beat burst with another AW held in the stage.
    do_reset();
    s_awready = 1'b0;
    set_aw(1, 1'b1, 5'd2, 32'h6000, 3'd3); #1;
    step();
    set_aw(1, 1'b0, 5'd0, 32'h0, 3'd0);
    set_w(1, 1'b1, 32'h60000000, 1'b0); #1;
    check("s5_w_beat0", s_wvalid, 1'b1);
    step(); set_w(1, 1'b1, 32'h60000001, 1'b0); #1;
    step(); set_w(1, 1'b1, 32'h60000002, 1'b0);
    srst = 1'b1;
    step();
    check("s5_rst_awvalid", s_awvalid, 1'b0);
    check("s5_rst_wvalid", s_wvalid, 1'b0);
    check("s5_rst_wready", m_wready, 2'b00);
    srst = 1'b0;
    $display("seq reset mid-burst: done");

    // Randomized traffic against the queue model.
    do_reset();
    for (int m = 0; m < MST; m++) begin
      aw_sent[m] = 0; w_txn[m] = 0; w_beat[m] = 0; aw_hold[m] = 0; w_hold[m] = 0;
      for (int t = 0; t < N; t++) begin
        t_addr[m][t] = $urandom;
        t_len[m][t]  = $urandom_range(0, 3);
      end
    end
    last_winner = MST - 1;
    begin
      bit done;
      int cyc;
      done = 0;
      cyc = 0;
      while (!done && cyc < 3000) begin
        bit exp_en, exp_wv;
        int exp_w, h, bidx;
        logic [MST-1:0] exp_mask, exp_wr, exp_bv;
        for (int m = 0; m < MST; m++) begin
          int ta, tw;
          if (!aw_hold[m] && aw_sent[m] < N && $urandom_range(0, 3) != 0) aw_hold[m] = 1;
          if (!w_hold[m] && w_txn[m] < N && $urandom_range(0, 3) != 0) w_hold[m] = 1;
          ta = (aw_sent[m] < N) ? aw_sent[m] : 0;
          tw = (w_txn[m] < N) ? w_txn[m] : 0;
          set_aw(m, aw_hold[m], 5'(m * 8 + ta), t_addr[m][ta], 3'(t_len[m][ta]));
          set_w(m, w_hold[m], beat_data(m, tw, w_beat[m]), w_beat[m] == t_len[m][tw]);
        end
        s_awready = ($urandom_range(0, 3) != 0);
        s_wready  = ($urandom_range(0, 3) != 0);
        s_bid     = 6'($urandom);
        s_bresp   = 2'($urandom);
        s_bvalid  = 1'($urandom);
        m_bready  = 2'($urandom);
        #1;
        exp_en = (grant_q.size() == 0 || s_awready) && order_q.size() < DEPTH;
        exp_w = -1;
        if (exp_en) begin
          for (int k = 1; k <= MST; k++) begin
            int c;
            c = (last_winner + k) % MST;
            if (exp_w < 0 && aw_hold[c]) exp_w = c;
          end
        end
        exp_mask = (exp_w >= 0) ? (MST'(1) << mb(exp_w)) : '0;
        check("rand_awready", m_awready, exp_mask);
        check("rand_awvalid", s_awvalid, grant_q.size() != 0);
        if (s_awvalid && s_awready && grant_q.size() > 0) begin
          gnt_t g;
          g = grant_q.pop_front();
          check("rand_awid", s_awid, {1'(g.m), 5'(g.m * 8 + g.t)});
          check("rand_awaddr", s_awaddr, t_addr[g.m][g.t]);
          check("rand_awlen", s_awlen, 3'(t_len[g.m][g.t]));
          check("rand_awsize", s_awsize, 3'd2);
          $display("rand aw: master=%0d txn=%0d id=%h len=%0d", g.m, g.t, s_awid, s_awlen);
        end
        exp_wv = 0; exp_wr = '0; h = 0;
        if (order_q.size() > 0) begin
          h = order_q[0];
          exp_wv = w_hold[h];
          exp_wr = s_wready ? (MST'(1) << mb(h)) : '0;
        end
        check("rand_wvalid", s_wvalid, exp_wv);
        check("rand_wready", m_wready, exp_wr);
        if (exp_wv && s_wready) begin
          bit last;
          last = (w_beat[h] == t_len[h][w_txn[h]]);
          check("rand_wdata", s_wdata, beat_data(h, w_txn[h], w_beat[h]));
          check("rand_wlast", s_wlast, last);
          w_hold[h] = 0;
          if (last) begin
            void'(order_q.pop_front());
            w_txn[h]++;
            w_beat[h] = 0;
          end else begin
            w_beat[h]++;
          end
        end
        if (exp_w >= 0) begin
          grant_q.push_back('{exp_w, aw_sent[exp_w]});
          order_q.push_back(exp_w);
          aw_sent[exp_w]++;
          aw_hold[exp_w] = 0;
          last_winner = exp_w;
        end
        bidx = int'(s_bid[SIDW-1]);
        exp_bv = s_bvalid ? (MST'(1) << mb(bidx)) : '0;
        check("rand_bvalid", m_bvalid, exp_bv);
        check("rand_bready", s_bready, m_bready[mb(bidx)]);
        step();
        cyc++;
        done = 1;
        for (int m = 0; m < MST; m++) begin
          if (aw_sent[m] < N || w_txn[m] < N) done = 0;
        end
        if (grant_q.size() != 0) done = 0;
      end
      check("rand_complete", done, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
